// File: rtl/approx_adder_pkg.sv
// rtl/approx_adder_pkg.sv - full-adder cell models and width helpers for the approximate adder
//
// Purpose : shared cell functions used by every segment, plus the error-square width helper.
// Contents: approx_fa / exact_fa return {S, Cout}; err_sq_width(w) gives the bit width of out_err squared.
package approx_adder_pkg;

    // Approximate cell: the sum ignores most of the carry logic and the carry out is always set.
    function automatic logic [1:0] approx_fa(input logic x, input logic y, input logic z);
        return {~z & (~x | y), 1'b1};
    endfunction

    function automatic logic [1:0] exact_fa(input logic x, input logic y, input logic z);
        return {x ^ y ^ z, (x & y) | (x & z) | (y & z)};
    endfunction

    // |out_err| fits in w+1 bits; the square is kept with two bits of headroom.
    function automatic int err_sq_width(input int w);
        return 2 * w + 4;
    endfunction

endpackage

// File: rtl/approx_rc_segment.sv
// rtl/approx_rc_segment.sv - combinational SEG-bit ripple segment computing approximate and exact sums
//
// Purpose : one pipeline slice of both adders. Bit (base+j) uses the approximate cell when it is below k.
// Ports   : a, b            - operand bits of this segment
//           c_apx_in/c_ex_in - carries from the previous segment (approximate / exact chain)
//           base            - absolute index of bit 0 of this segment
//           k               - approximate bit count (already clamped to W)
//           s_apx/s_ex      - segment sum bits for each chain
//           c_apx_out/c_ex_out - carries out of the segment
module approx_rc_segment #(
    parameter int SEG = 4,
    parameter int KW  = 5
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           c_apx_in,
    input  logic           c_ex_in,
    input  logic [KW-1:0]  base,
    input  logic [KW-1:0]  k,
    output logic [SEG-1:0] s_apx,
    output logic [SEG-1:0] s_ex,
    output logic           c_apx_out,
    output logic           c_ex_out
);
    import approx_adder_pkg::*;

    logic          c_apx;
    logic          c_ex;
    logic [1:0]    r_apx;
    logic [1:0]    r_ex;
    logic [KW-1:0] idx;

    always_comb begin
        s_apx = '0;
        s_ex  = '0;
        c_apx = c_apx_in;
        c_ex  = c_ex_in;
        r_apx = '0;
        r_ex  = '0;
        idx   = '0;
        for (int j = 0; j < SEG; j++) begin
            idx = base + KW'(j);
            if (idx < k) begin
                r_apx = approx_fa(a[j], b[j], c_apx);
            end else begin
                r_apx = exact_fa(a[j], b[j], c_apx);
            end
            s_apx[j] = r_apx[1];
            c_apx    = r_apx[0];
            r_ex     = exact_fa(a[j], b[j], c_ex);
            s_ex[j]  = r_ex[1];
            c_ex     = r_ex[0];
        end
        c_apx_out = c_apx;
        c_ex_out  = c_ex;
    end

endmodule

// File: rtl/approx_adder_mse_pipe.sv
// rtl/approx_adder_mse_pipe.sv - pipelined approximate adder with exact reference and error statistics
//
// Purpose : W/SEG-stage ripple adder; each pair carries its own approximation depth k.
// Ports   : clk, rst (sync, active-high)
//           in_valid/in_ready, in_a, in_b, in_k   - operand stream (k > W treated as W)
//           out_valid/out_ready, out_sum, out_exact, out_err - result stream
//           clr_stats                              - clear statistics (a same-cycle handshake is loaded)
//           sample_cnt, sse, max_abs_err           - saturating statistics over consumed results
module approx_adder_mse_pipe #(
    parameter int W     = 16,
    parameter int SEG   = 4,
    parameter int ACC_W = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_a,
    input  logic [W-1:0]           in_b,
    input  logic [$clog2(W+1)-1:0] in_k,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W:0]             out_sum,
    output logic [W:0]             out_exact,
    output logic signed [W+1:0]    out_err,
    input  logic                   clr_stats,
    output logic [31:0]            sample_cnt,
    output logic [ACC_W-1:0]       sse,
    output logic [W:0]             max_abs_err
);
    import approx_adder_pkg::*;

    localparam int NSTAGE = W / SEG;
    localparam int KW     = $clog2(W + 1);
    localparam int SQ_W   = err_sq_width(W);
    localparam int SUM_W  = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;
    localparam logic [KW-1:0]    K_MAX   = KW'(W);
    localparam logic [SUM_W-1:0] SSE_MAX = SUM_W'({ACC_W{1'b1}});

    // Each stage carries the full operands and k so later segments can read their slice.
    typedef struct packed {
        logic          vld;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [KW-1:0] k;
        logic [W-1:0]  s_apx;
        logic [W-1:0]  s_ex;
        logic          c_apx;
        logic          c_ex;
    } stage_t;

    stage_t stage_q [NSTAGE];
    stage_t stage_d [NSTAGE];

    logic [SEG-1:0] seg_a     [NSTAGE];
    logic [SEG-1:0] seg_b     [NSTAGE];
    logic [KW-1:0]  seg_k     [NSTAGE];
    logic           seg_ci_apx[NSTAGE];
    logic           seg_ci_ex [NSTAGE];
    logic [SEG-1:0] seg_s_apx [NSTAGE];
    logic [SEG-1:0] seg_s_ex  [NSTAGE];
    logic           seg_co_apx[NSTAGE];
    logic           seg_co_ex [NSTAGE];

    logic [KW-1:0]          k_in;
    logic                   stall;
    logic                   hs;
    logic signed [W+1:0]    neg_err;
    logic [W:0]             abs_err;
    logic [SQ_W-1:0]        err_sq;

    logic [31:0]      cnt_q, cnt_d, cnt_base;
    logic [ACC_W-1:0] sse_q, sse_d, sse_base;
    logic [W:0]       max_q, max_d, max_base;
    logic [SUM_W-1:0] sse_sum;

    assign k_in = (in_k > K_MAX) ? K_MAX : in_k;

    // Segment 0 works on the incoming pair; segment s works on stage s-1 registers.
    for (genvar s = 0; s < NSTAGE; s++) begin : g_seg
        if (s == 0) begin : g_first
            assign seg_a[s]      = in_a[SEG-1:0];
            assign seg_b[s]      = in_b[SEG-1:0];
            assign seg_k[s]      = k_in;
            assign seg_ci_apx[s] = 1'b0;
            assign seg_ci_ex[s]  = 1'b0;
        end else begin : g_rest
            assign seg_a[s]      = stage_q[s-1].a[s*SEG +: SEG];
            assign seg_b[s]      = stage_q[s-1].b[s*SEG +: SEG];
            assign seg_k[s]      = stage_q[s-1].k;
            assign seg_ci_apx[s] = stage_q[s-1].c_apx;
            assign seg_ci_ex[s]  = stage_q[s-1].c_ex;
        end

        approx_rc_segment #(
            .SEG (SEG),
            .KW  (KW)
        ) u_seg (
            .a         (seg_a[s]),
            .b         (seg_b[s]),
            .c_apx_in  (seg_ci_apx[s]),
            .c_ex_in   (seg_ci_ex[s]),
            .base      (KW'(s * SEG)),
            .k         (seg_k[s]),
            .s_apx     (seg_s_apx[s]),
            .s_ex      (seg_s_ex[s]),
            .c_apx_out (seg_co_apx[s]),
            .c_ex_out  (seg_co_ex[s])
        );
    end

    assign out_valid = stage_q[NSTAGE-1].vld;
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign hs        = out_valid & out_ready;

    assign out_sum   = {stage_q[NSTAGE-1].c_apx, stage_q[NSTAGE-1].s_apx};
    assign out_exact = {stage_q[NSTAGE-1].c_ex, stage_q[NSTAGE-1].s_ex};
    assign out_err   = $signed({1'b0, out_sum}) - $signed({1'b0, out_exact});
    assign neg_err   = -out_err;
    assign abs_err   = out_err[W+1] ? neg_err[W:0] : out_err[W:0];
    assign err_sq    = SQ_W'(abs_err) * SQ_W'(abs_err);

    // Global stall: the whole pipe holds, so results never reorder or compact.
    always_comb begin
        for (int s = 0; s < NSTAGE; s++) begin
            stage_d[s] = stage_q[s];
        end
        if (!stall) begin
            stage_d[0].vld               = in_valid;
            stage_d[0].a                 = in_a;
            stage_d[0].b                 = in_b;
            stage_d[0].k                 = k_in;
            stage_d[0].s_apx             = '0;
            stage_d[0].s_ex              = '0;
            stage_d[0].s_apx[SEG-1:0]    = seg_s_apx[0];
            stage_d[0].s_ex[SEG-1:0]     = seg_s_ex[0];
            stage_d[0].c_apx             = seg_co_apx[0];
            stage_d[0].c_ex              = seg_co_ex[0];
            for (int s = 1; s < NSTAGE; s++) begin
                stage_d[s]                       = stage_q[s-1];
                stage_d[s].s_apx[s*SEG +: SEG]   = seg_s_apx[s];
                stage_d[s].s_ex[s*SEG +: SEG]    = seg_s_ex[s];
                stage_d[s].c_apx                 = seg_co_apx[s];
                stage_d[s].c_ex                  = seg_co_ex[s];
            end
        end
    end

    // Clearing selects a zero base, so a same-cycle handshake is loaded on top of it.
    always_comb begin
        cnt_base = clr_stats ? '0 : cnt_q;
        sse_base = clr_stats ? '0 : sse_q;
        max_base = clr_stats ? '0 : max_q;
        cnt_d    = cnt_base;
        sse_d    = sse_base;
        max_d    = max_base;
        sse_sum  = SUM_W'(sse_base) + SUM_W'(err_sq);
        if (hs) begin
            if (cnt_base != '1) begin
                cnt_d = cnt_base + 32'd1;
            end
            sse_d = (sse_sum > SSE_MAX) ? '1 : sse_sum[ACC_W-1:0];
            if (abs_err > max_base) begin
                max_d = abs_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NSTAGE; s++) begin
                stage_q[s] <= '0;
            end
            cnt_q <= '0;
            sse_q <= '0;
            max_q <= '0;
        end else begin
            for (int s = 0; s < NSTAGE; s++) begin
                stage_q[s] <= stage_d[s];
            end
            cnt_q <= cnt_d;
            sse_q <= sse_d;
            max_q <= max_d;
        end
    end

    assign sample_cnt  = cnt_q;
    assign sse         = sse_q;
    assign max_abs_err = max_q;

endmodule

// File: tb/tb_approx_adder_mse_pipe.sv
// tb/tb_approx_adder_mse_pipe.sv - directed table-driven bench for approx_adder_mse_pipe
module tb_approx_adder_mse_pipe;
    localparam int W      = 16;
    localparam int SEG    = 4;
    localparam int ACC_W  = 48;
    localparam int NSTAGE = W / SEG;
    localparam int KW     = $clog2(W + 1);
    localparam int NVEC   = 10;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [W-1:0]        in_a;
    logic [W-1:0]        in_b;
    logic [KW-1:0]       in_k;
    logic                out_valid;
    logic                out_ready;
    logic [W:0]          out_sum;
    logic [W:0]          out_exact;
    logic signed [W+1:0] out_err;
    logic                clr_stats;
    logic [31:0]         sample_cnt;
    logic [ACC_W-1:0]    sse;
    logic [W:0]          max_abs_err;

    always #5 clk = ~clk;

    approx_adder_mse_pipe #(
        .W     (W),
        .SEG   (SEG),
        .ACC_W (ACC_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_k        (in_k),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_exact   (out_exact),
        .out_err     (out_err),
        .clr_stats   (clr_stats),
        .sample_cnt  (sample_cnt),
        .sse         (sse),
        .max_abs_err (max_abs_err)
    );

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [KW-1:0] k;
        logic [W:0]    sum;
        logic [W:0]    exact;
        int            err;
    } vec_t;

    typedef struct {
        logic [W:0]          sum;
        logic [W:0]          exact;
        logic signed [W+1:0] err;
    } res_t;

    vec_t vecs [NVEC];
    res_t rq [$];
    int   tests = 0;
    int   fails = 0;
    int   ok_s;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            rq.push_back(res_t'{out_sum, out_exact, out_err});
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vec_t v, output int ok);
        in_a     = v.a;
        in_b     = v.b;
        in_k     = v.k;
        in_valid = 1'b1;
        ok       = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("send_accept", ok, 1);
    endtask

    task automatic wait_results(input int n);
        int c = 0;
        while (rq.size() < n && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("result_count", rq.size(), n);
    endtask

    task automatic check_res(input vec_t v, input string tag);
        res_t r;
        if (rq.size() > 0) begin
            r = rq.pop_front();
        end else begin
            r.sum   = 'x;
            r.exact = 'x;
            r.err   = 'x;
        end
        check({tag, "_sum"}, r.sum, v.sum);
        check({tag, "_exact"}, r.exact, v.exact);
        check({tag, "_err"}, r.err, v.err);
    endtask

    task automatic clear_stats();
        clr_stats = 1'b1;
        sync();
        clr_stats = 1'b0;
    endtask

    task automatic check_stats(input string tag, input longint cnt, input longint sq, input longint mx);
        check({tag, "_cnt"}, sample_cnt, cnt);
        check({tag, "_sse"}, sse, sq);
        check({tag, "_max"}, max_abs_err, mx);
    endtask

    task automatic check_latency(input string tag);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check(tag, lat, NSTAGE);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        longint m_sse;
        longint m_max;
        longint ae;

        vecs[0] = '{16'h1234, 16'h4321, 5'd0,  17'h05555, 17'h05555, 0};
        vecs[1] = '{16'h0000, 16'h0000, 5'd12, 17'h01001, 17'h00000, 4097};
        vecs[2] = '{16'h0000, 16'h0000, 5'd16, 17'h10001, 17'h00000, 65537};
        vecs[3] = '{16'h0001, 16'h0001, 5'd1,  17'h00003, 17'h00002, 1};
        vecs[4] = '{16'hFFFF, 16'h0001, 5'd0,  17'h10000, 17'h10000, 0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 5'd16, 17'h10001, 17'h1FFFE, -65533};
        vecs[6] = '{16'h0000, 16'h0000, 5'd20, 17'h10001, 17'h00000, 65537};
        vecs[7] = '{16'h00F0, 16'h0F0F, 5'd4,  17'h01001, 17'h00FFF, 2};
        vecs[8] = '{16'h00FF, 16'h0000, 5'd8,  17'h00100, 17'h000FF, 1};
        vecs[9] = '{16'h0003, 16'h0003, 5'd2,  17'h00005, 17'h00006, -1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_k      = '0;
        out_ready = 1'b1;
        clr_stats = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check_stats("reset", 0, 0, 0);

        // Single pair, exact everywhere, with latency measurement.
        sync();
        send(vecs[0], ok_s);
        check_latency("latency_v0");
        wait_results(1);
        check_res(vecs[0], "v0");
        repeat (2) @(negedge clk);
        check_stats("v0", 1, 0, 0);

        // k=12 on zero operands from cleared statistics.
        sync();
        clear_stats();
        send(vecs[1], ok_s);
        wait_results(1);
        check_res(vecs[1], "k12");
        repeat (2) @(negedge clk);
        check_stats("k12", 1, 16785409, 4097);

        // Full-width approximation followed by k=1.
        sync();
        clear_stats();
        send(vecs[2], ok_s);
        send(vecs[3], ok_s);
        wait_results(2);
        check_res(vecs[2], "k16");
        check_res(vecs[3], "k1");
        repeat (2) @(negedge clk);
        check_stats("k16_k1", 2, 64'd4295098370, 65537);

        // Whole table back-to-back with out_ready held high.
        sync();
        clear_stats();
        @(negedge clk);
        check_stats("clr_only", 0, 0, 0);
        sync();
        for (int i = 0; i < NVEC; i++) begin
            send(vecs[i], ok_s);
        end
        wait_results(NVEC);
        m_sse = 0;
        m_max = 0;
        for (int i = 0; i < NVEC; i++) begin
            check_res(vecs[i], $sformatf("tbl%0d", i));
            ae    = (vecs[i].err < 0) ? -longint'(vecs[i].err) : longint'(vecs[i].err);
            m_sse = m_sse + ae * ae;
            if (ae > m_max) m_max = ae;
        end
        repeat (2) @(negedge clk);
        check_stats("table", NVEC, m_sse, m_max);

        // Back-pressure: six pairs while out_ready is low for five cycles.
        sync();
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(vecs[i + 3], ok_s);
                end
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready_low", in_ready, 0);
                check("stall_out_valid", out_valid, 1);
                check("stall_hold_sum", out_sum, vecs[3].sum);
                check("stall_no_output", rq.size(), 0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                #1;
                check("stall_in_ready_recover", in_ready, 1);
            end
        join
        wait_results(6);
        repeat (8) @(negedge clk);
        check("stall_no_dup", rq.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check_res(vecs[i + 3], $sformatf("stall%0d", i));
        end

        // clr_stats in the same cycle as a handshake carrying err=+1.
        sync();
        out_ready = 1'b0;
        send(vecs[3], ok_s);
        check_latency("latency_clr");
        sync();
        clr_stats = 1'b1;
        out_ready = 1'b1;
        sync();
        clr_stats = 1'b0;
        @(negedge clk);
        check_stats("clr_hs", 1, 1, 1);
        wait_results(1);
        check_res(vecs[3], "clr_hs");

        // Reset with three pairs in flight.
        sync();
        send(vecs[0], ok_s);
        send(vecs[1], ok_s);
        send(vecs[2], ok_s);
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check_stats("rst", 0, 0, 0);
        repeat (8) @(negedge clk);
        check("rst_discard", rq.size(), 0);
        sync();
        send(vecs[7], ok_s);
        check_latency("latency_after_rst");
        wait_results(1);
        check_res(vecs[7], "after_rst");
        repeat (2) @(negedge clk);
        check_stats("after_rst", 1, 4, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
